// File: rtl/bcm_inverse_scan.sv
// bcm_inverse_scan: enumerates every 3-bit symbol whose BCM code equals a
// requested 2-bit code. Symbols come out in ascending order on a
// valid/ready stream.
// Optional macro BCM_INV_FAST_EN: when it is defined, SCAN finds the next
// matching symbol in a single cycle. When it is undefined, SCAN tests one
// index per cycle. Both builds emit the same symbols in the same order.
module bcm_inverse_scan #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_data,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       code_r, code_n;
    logic [2:0]       idx, idx_n;
    logic [2:0]       data_n;
    logic [CNT_W-1:0] cnt_n;
    logic             hit;
    logic [2:0]       hit_idx;
    logic             scan_end;

    // Forward BCM map. It is many-to-one, which is the reason this block exists.
    function automatic logic [1:0] bcm_map(input logic [2:0] d);
        logic [1:0] o;
        case (d)
            3'd0:    o = 2'b01;
            3'd1:    o = 2'b11;
            3'd2:    o = 2'b00;
            3'd3:    o = 2'b10;
            3'd4:    o = 2'b01;
            3'd5:    o = 2'b10;
            3'd6:    o = 2'b11;
            default: o = 2'b01;
        endcase
        return o;
    endfunction

`ifdef BCM_INV_FAST_EN
    // Priority search over indices >= idx. The loop runs downward so the
    // lowest matching index is the last one assigned and therefore wins.
    // A miss always ends the scan.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = idx;
        scan_end = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (3'(i) >= idx && bcm_map(3'(i)) == code_r) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end
`else
    // Test one index per cycle. The scan ends after index 7 has been tested.
    always_comb begin
        hit      = (bcm_map(idx) == code_r);
        hit_idx  = idx;
        scan_end = (idx == 3'd7);
    end
`endif

    // out_last is high when no symbol above the current one maps to the
    // captured code.
    always_comb begin
        out_last = (state == EMIT);
        for (int i = 0; i < 8; i++) begin
            if (3'(i) > out_data && bcm_map(3'(i)) == code_r)
                out_last = 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign done      = (state == DONE);

    // Next-state and datapath update.
    always_comb begin
        state_n = state;
        code_n  = code_r;
        idx_n   = idx;
        data_n  = out_data;
        cnt_n   = match_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    code_n  = req_code;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    data_n  = hit_idx;
                    cnt_n   = match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_n = EMIT;
                end else if (scan_end) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            EMIT: begin
                // Stall here while out_ready is low. All registers hold.
                if (out_ready) begin
                    if (out_data == 3'd7) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = out_data + 3'd1;
                        state_n = SCAN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code_r    <= 2'b00;
            idx       <= 3'd0;
            out_data  <= 3'd0;
            match_cnt <= '0;
        end else begin
            state     <= state_n;
            code_r    <= code_n;
            idx       <= idx_n;
            out_data  <= data_n;
            match_cnt <= cnt_n;
        end
    end

endmodule

// File: doc/bcm_inverse_scan.md
Name: bcm_inverse_scan

Overview:
- Inverse of the team's 3-bit to 2-bit BCM code map: given a 2-bit code, emits every 3-bit symbol that maps to it, in ascending order, over a valid/ready stream.
- Used by test and analysis logic to enumerate the preimage of a received BCM code, since the forward map is not one-to-one.
- Fixed map (d -> o): 000->01, 001->11, 010->00, 011->10, 100->01, 101->10, 110->11, 111->01.
- Preimage sizes: code 01 has 3 symbols, 11 has 2, 10 has 2, 00 has 1.

Parameters:
- CNT_W, 4, width of match_cnt; must be >= 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request strobe.
- req_ready  output  1  high only in IDLE.
- req_code  input  2  code to invert; captured on accept.
- out_valid  output  1  out_data holds a matching symbol.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  3  matching 3-bit symbol.
- out_last  output  1  qualifies out_valid; no higher symbol maps to the code.
- done  output  1  one-cycle pulse at end of scan.
- match_cnt  output  CNT_W  number of symbols emitted in the current or last scan.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, out_valid=0, out_data=0, out_last=0, done=0, match_cnt=0, idx=0.
- Reset mid-scan aborts to IDLE. No partial output is emitted after reset.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - req_valid && req_ready captures req_code into code_r, clears idx and match_cnt, and goes to SCAN.
  - req_code changes outside the accept cycle are ignored.
- SCAN (baseline): evaluates one index per cycle.
  - If map(idx)==code_r: out_data<=idx, increment match_cnt, go to EMIT.
  - Otherwise, if idx==7, go to DONE.
  - Otherwise, idx<=idx+1 and stay in SCAN.
- EMIT:
  - out_valid=1. out_data and out_last are held stable until out_ready.
  - On handshake: if out_data==7, go to DONE; otherwise idx<=out_data+1 and go to SCAN.
  - out_valid drops the cycle after the handshake.
- out_last: combinational from code_r and out_data. It is 1 iff no symbol greater than out_data maps to code_r.
- DONE: done=1 for exactly one cycle, then IDLE. match_cnt holds until the next accept.
- Every code has at least one match, so every scan emits 1-3 outputs.
- Baseline latency, code 00 with out_ready=1 (accept at T):
  - SCAN idx0..2 at T+1..T+3.
  - EMIT 010 at T+4.
  - SCAN idx3..7 at T+5..T+9.
  - done at T+10.
  - req_ready high again at T+11.
- out_ready low stalls only EMIT; state, idx and data are frozen.
- Arithmetic: idx is 3 bits. Wrap past 7 never occurs, because the idx==7 checks route to DONE first.

Optional Feature:
- Macro: BCM_INV_FAST_EN.
- Defined: SCAN is a single-cycle priority search over indices >= idx.
  - If any index matches, the lowest matching index goes to out_data, match_cnt increments, and the block goes to EMIT.
  - If none match, the block goes to DONE.
  - Code 00, accept at T: SCAN at T+1, EMIT 010 at T+2, SCAN (no match) at T+3, done at T+4.
- Undefined: baseline one-index-per-cycle scan. Output order and values are identical in both modes; only latency differs.

Test Plan:
- Reset, then code 01 with out_ready=1 -> outputs 000, 100, 111; out_last only on 111; done pulse; match_cnt=3.
- Code 00 with out_ready=1 -> single output 010 with out_last=1.
  - Baseline: done at T+10. FAST: done at T+4. match_cnt=1.
- Code 11 with out_ready held low 5 cycles at each EMIT -> 001 then 110, held stable while stalled; out_last on 110; match_cnt=2.
- Code 10, req_code toggled during scan, req_valid held high -> outputs 011 and 101 only.
  - Second request accepted only after done; req_ready=0 throughout the scan.
- Assert rst during EMIT of the first symbol for code 01 -> next cycle IDLE, out_valid=0, match_cnt=0, done never pulses.
  - A new request for code 00 then completes normally.
- Back-to-back requests 01, 11, 10, 00 -> total 8 outputs covering each symbol 000-111 exactly once across the scans.
